backprop_sequencer: RTL and testbench
=====================================

# backprop_sequencer

Control block that drives the backprop datapath pipeline (activation-derivative and downstream weight stages) through one full backward pass. Per layer, from the cost layer down to layer 0, it issues row descriptors over a valid/ready handshake: gradient rows first, then weight-update rows. It tracks in-flight rows so that a layer's gradient rows complete before its update rows, and before the next layer starts. It sits between the training top-level (start/done) and the first register stage of the pipeline.

## Interface
- `num_layers`, 2: number of dense layers (≥1); layer `num_layers-1` is the cost layer.
- `size`, 3: rows per layer (≥1), same as the datapath vector size.
- `max_outstanding`, 8: maximum rows in flight; must be ≥ pipeline depth for full throughput.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a pass; ignored unless idle.
- `issue_ready` in 1: pipeline can accept a row this cycle.
- `retire_valid` in 1: one row left the pipeline end this cycle.
- `issue_valid` out 1: row descriptor valid.
- `w_layer_index` out 32: layer of the issued row.
- `w_row_index` out 32: row within the layer.
- `is_update` out 1: 1 = update row, 0 = gradient row.
- `is_cost_layer` out 1: row belongs to layer `num_layers-1`.
- `backprop_cost` out 1: gradient row of the cost layer (cost derivative is injected).
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at pass completion.
- `error` out 1: sticky; set by a retire with zero rows outstanding, or by an overflow attempt.

## Operation
- States: IDLE, GRAD, DRAIN_G, UPD, DRAIN_U, DONE.
- IDLE + `start` → GRAD: layer = `num_layers-1`, row = 0. `error` is cleared when the pass starts.
- GRAD/UPD: present the descriptor for (layer, row). On handshake (`issue_valid & issue_ready`), row++. After row `size-1` is accepted:
  - GRAD → DRAIN_G.
  - UPD → DRAIN_U.
- DRAIN_G: wait until outstanding == 0, then → UPD with row = 0 on the same layer.
- DRAIN_U: wait until outstanding == 0, then:
  - if layer == 0 → DONE;
  - otherwise layer--, row = 0, → GRAD.
- DONE: assert `done` for one cycle → IDLE.
- `is_cost_layer` = (layer == `num_layers-1`) in GRAD and UPD.
- `backprop_cost` = `is_cost_layer` & GRAD.
- Outstanding counter update per cycle:
  - handshake only: +1;
  - `retire_valid` only: −1;
  - both in the same cycle: unchanged.
- `issue_valid` is deasserted while outstanding == `max_outstanding`.
- `retire_valid` with outstanding == 0: counter holds at 0 and `error` is set.
- `start` while busy: ignored, with no effect on state.
- `retire_valid` in IDLE is legal only if outstanding > 0; otherwise the error rule above applies.

## Timing
- All outputs are registered. Reset values are all zero: `issue_valid`, indices, flags, `busy`, `done`, `error`; state = IDLE; outstanding = 0.
- `start` sampled at edge N:
  - `busy` = 1 and `issue_valid` = 1 from cycle N+1;
  - first descriptor = (layer `num_layers-1`, row 0).
- Descriptor fields are stable while `issue_valid & !issue_ready`. They advance only in the cycle after a handshake.
- With `issue_ready` held at 1, GRAD/UPD issue one row per cycle with no bubbles.
- A drain state exits in the cycle after outstanding reaches 0. The first descriptor of the next phase appears the following cycle.
- `done` is high exactly one cycle. `busy` falls together with `done`; `start` is accepted again from the next edge.
- Reset asserted mid-pass: state goes immediately (asynchronously) to IDLE with all outputs 0. Rows in flight are forgotten, and the counter restarts at 0.

## Structure
- Shared package `backprop_pkg` holds:
  - `seq_state_t` enum (IDLE, GRAD, DRAIN_G, UPD, DRAIN_U, DONE);
  - `INDEX_W` = 32 (layer/row index width).
- One sub-module `inflight_counter`, with parameter `max_outstanding` and inputs inc, dec, clk, reset. It outputs count, full, empty, underflow, and its counter width is `$clog2(max_outstanding+1)`.
- The FSM, index counters and output registers live in `backprop_sequencer`.

## Test plan
- Defaults, `issue_ready`=1, bench retires each row 4 cycles after issue → descriptors are issued in this order:
  - (1,0..2,upd=0,cost=1,bpc=1);
  - drain;
  - (1,0..2,upd=1,cost=1,bpc=0);
  - drain;
  - (0,0..2,upd=0,cost=0);
  - drain;
  - (0,0..2,upd=1);
  - then `done` pulses once and `error` = 0.
- `issue_ready` toggles 1/0 every cycle → descriptors hold during stalls; same 12-row sequence; no row is duplicated or skipped.
- `max_outstanding`=2, retire latency 4 → at most 2 rows in flight; `issue_valid` drops while full; pass still completes.
- `retire_valid` pulsed in IDLE with outstanding 0 → `error`=1, counter stays 0; the next `start` clears `error`.
- `start` pulsed during GRAD → ignored; sequence is identical to the first scenario.
- `reset` asserted during UPD of layer 1 → outputs 0 immediately; a fresh `start` restarts at (1,0,upd=0).

Source files
------------

// File: rtl/backprop_sequencer_pkg.sv
// rtl/backprop_sequencer_pkg.sv - shared types for the backward-pass sequencer
package backprop_pkg;

   localparam int INDEX_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      GRAD,
      DRAIN_G,
      UPD,
      DRAIN_U,
      DONE
   } seq_state_t;

endpackage

// File: rtl/backprop_sequencer_if.sv
// rtl/backprop_sequencer_if.sv - row descriptor issue and retire handshake
interface backprop_sequencer_if;
   import backprop_pkg::*;

   logic               issue_valid;
   logic               issue_ready;
   logic [INDEX_W-1:0] w_layer_index;
   logic [INDEX_W-1:0] w_row_index;
   logic               is_update;
   logic               is_cost_layer;
   logic               backprop_cost;
   logic               retire_valid;

   modport master (
      output issue_valid, w_layer_index, w_row_index, is_update, is_cost_layer, backprop_cost,
      input  issue_ready, retire_valid
   );

   modport slave (
      input  issue_valid, w_layer_index, w_row_index, is_update, is_cost_layer, backprop_cost,
      output issue_ready, retire_valid
   );
endinterface

// File: rtl/backprop_sequencer_inflight_counter.sv
// rtl/backprop_sequencer_inflight_counter.sv - rows-in-flight counter
// Simultaneous inc and dec leave the count unchanged; dec at zero holds and flags underflow.
module inflight_counter #(
   parameter int max_outstanding = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   inc,
   input  logic                                   dec,
   output logic [$clog2(max_outstanding+1)-1:0]   count,
   output logic                                   full,
   output logic                                   empty,
   output logic                                   underflow
);
   localparam int CW = $clog2(max_outstanding + 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !empty) begin
         count <= count - 1'b1;
      end
   end

   assign full      = (count == CW'(max_outstanding));
   assign empty     = (count == '0);
   assign underflow = dec && !inc && empty;
endmodule

// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - backward-pass row sequencer
// Walks layers from the cost layer down, issuing gradient then update rows with drains between phases.
module backprop_sequencer
   import backprop_pkg::*;
#(
   parameter int num_layers      = 2,
   parameter int size            = 3,
   parameter int max_outstanding = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   backprop_sequencer_if.master        bus,
   output logic                        busy,
   output logic                        done,
   output logic                        error
);
   localparam int                 CW         = $clog2(max_outstanding + 1);
   localparam logic [INDEX_W-1:0] LAST_LAYER = INDEX_W'(num_layers - 1);
   localparam logic [INDEX_W-1:0] LAST_ROW   = INDEX_W'(size - 1);

   seq_state_t         state, state_d;
   logic [INDEX_W-1:0] layer, layer_d, row, row_d;
   logic               issue_valid, issue_valid_d;
   logic               update, update_d, cost, cost_d, bpc, bpc_d;
   logic               busy_d, done_d, error_d, active_d;
   logic [CW-1:0]      count;
   logic               full, empty, underflow;
   logic               hs, will_be_full;

   assign hs = issue_valid && bus.issue_ready;

   inflight_counter #(.max_outstanding(max_outstanding)) u_inflight (
      .clk       (clk),
      .reset     (reset),
      .inc       (hs),
      .dec       (bus.retire_valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .underflow (underflow)
   );

   // issue_valid is registered, so gate it with the count as it will be after this edge
   assign will_be_full = hs ? (count == CW'(max_outstanding - 1)) && !bus.retire_valid
                            : full && !bus.retire_valid;

   always_comb begin
      state_d = state;
      layer_d = layer;
      row_d   = row;
      error_d = error || underflow || (hs && full);
      case (state)
         IDLE: begin
            if (start) begin
               state_d = GRAD;
               layer_d = LAST_LAYER;
               row_d   = '0;
               error_d = underflow;
            end
         end
         GRAD, UPD: begin
            if (hs) begin
               if (row == LAST_ROW) begin
                  state_d = (state == GRAD) ? DRAIN_G : DRAIN_U;
                  row_d   = '0;
               end else begin
                  row_d = row + 1'b1;
               end
            end
         end
         DRAIN_G: begin
            if (empty) state_d = UPD;
         end
         DRAIN_U: begin
            if (empty) begin
               if (layer == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = GRAD;
                  layer_d = layer - 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      active_d      = (state_d == GRAD) || (state_d == UPD);
      issue_valid_d = active_d && !will_be_full;
      update_d      = (state_d == UPD);
      cost_d        = active_d && (layer_d == LAST_LAYER);
      bpc_d         = cost_d && (state_d == GRAD);
      busy_d        = (state_d != IDLE) && (state_d != DONE);
      done_d        = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         layer       <= '0;
         row         <= '0;
         issue_valid <= 1'b0;
         update      <= 1'b0;
         cost        <= 1'b0;
         bpc         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_d;
         layer       <= layer_d;
         row         <= row_d;
         issue_valid <= issue_valid_d;
         update      <= update_d;
         cost        <= cost_d;
         bpc         <= bpc_d;
         busy        <= busy_d;
         done        <= done_d;
         error       <= error_d;
      end
   end

   assign bus.issue_valid   = issue_valid;
   assign bus.w_layer_index = layer;
   assign bus.w_row_index   = row;
   assign bus.is_update     = update;
   assign bus.is_cost_layer = cost;
   assign bus.backprop_cost = bpc;
endmodule

// File: tb/tb_backprop_sequencer.sv
// tb/tb_backprop_sequencer.sv - scoreboard bench for backprop_sequencer
// DUT a uses max_outstanding 8, DUT b uses 2; both see identical start/ready stimulus.
module tb_backprop_sequencer;
   import backprop_pkg::*;

   localparam int NL = 2;
   localparam int SZ = 3;

   typedef struct packed {
      logic [31:0] layer;
      logic [31:0] row;
      logic        upd;
      logic        cost;
      logic        bpc;
   } desc_t;

   logic clk = 1'b0;
   logic reset, start;
   logic ready = 1'b1;
   logic busy_a, done_a, error_a, busy_b, done_b, error_b;

   always #5 clk = ~clk;

   backprop_sequencer_if bus_a ();
   backprop_sequencer_if bus_b ();

   assign bus_a.issue_ready = ready;
   assign bus_b.issue_ready = ready;

   backprop_sequencer #(.num_layers(NL), .size(SZ), .max_outstanding(8)) dut_a (
      .clk(clk), .reset(reset), .start(start), .bus(bus_a),
      .busy(busy_a), .done(done_a), .error(error_a));

   backprop_sequencer #(.num_layers(NL), .size(SZ), .max_outstanding(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .bus(bus_b),
      .busy(busy_b), .done(done_b), .error(error_b));

   int    checks = 0;
   int    passes = 0;
   desc_t exp_q [2][$];
   logic [7:0] pend [2];
   int    inflight [2];
   int    last_key [2];
   bit    last_hs [2];
   bit    prev_stall [2];
   desc_t prev_d [2];
   int    maxo [2];
   int    ready_mode = 0;
   int    lat_mode = 0;
   bit    extra_retire = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   function automatic desc_t sample(input int d);
      desc_t s;
      if (d == 0) s = '{bus_a.w_layer_index, bus_a.w_row_index, bus_a.is_update, bus_a.is_cost_layer, bus_a.backprop_cost};
      else        s = '{bus_b.w_layer_index, bus_b.w_row_index, bus_b.is_update, bus_b.is_cost_layer, bus_b.backprop_cost};
      return s;
   endfunction

   function automatic logic valid_of(input int d);
      return (d == 0) ? bus_a.issue_valid : bus_b.issue_valid;
   endfunction

   // Reference order: cost layer down to 0, gradient rows then update rows, rows ascending.
   task automatic push_pass();
      for (int d = 0; d < 2; d++)
         for (int l = NL - 1; l >= 0; l--)
            for (int u = 0; u < 2; u++)
               for (int r = 0; r < SZ; r++) begin
                  desc_t e;
                  e.layer = 32'(l);
                  e.row   = 32'(r);
                  e.upd   = (u == 1);
                  e.cost  = (l == NL - 1);
                  e.bpc   = (l == NL - 1) && (u == 0);
                  exp_q[d].push_back(e);
               end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         exp_q[d].delete();
         pend[d]       = '0;
         inflight[d]   = 0;
         last_key[d]   = -1;
         last_hs[d]    = 0;
         prev_stall[d] = 0;
      end
   endtask

   task automatic observe(input int d);
      desc_t s, e;
      logic  iv;
      bit    hs;
      int    pre, key, lat;
      s   = sample(d);
      iv  = valid_of(d);
      pre = inflight[d];
      hs  = iv && ready;
      if (pre == maxo[d]) check($sformatf("full_gate_dut%0d", d), 32'(iv), 0);
      if (prev_stall[d]) check($sformatf("stall_hold_dut%0d", d), 32'(iv && (s == prev_d[d])), 1);
      if (pend[d][0]) inflight[d]--;
      if (hs) begin
         key = int'(s.layer) * 2 + int'(s.upd);
         check($sformatf("row_expected_dut%0d", d), 32'(exp_q[d].size() > 0), 1);
         if (exp_q[d].size() > 0) begin
            e = exp_q[d].pop_front();
            checks++;
            if (s == e) passes++;
            else $display("FAIL desc_dut%0d: got (%0d,%0d,u%0d,c%0d,b%0d) expected (%0d,%0d,u%0d,c%0d,b%0d)",
                          d, s.layer, s.row, s.upd, s.cost, s.bpc, e.layer, e.row, e.upd, e.cost, e.bpc);
         end
         if (last_key[d] != -1 && key != last_key[d])
            check($sformatf("drained_before_phase_dut%0d", d), 32'(pre), 0);
         if (d == 0 && ready_mode == 0 && key == last_key[d])
            check("no_bubble_dut0", 32'(last_hs[d]), 1);
         inflight[d]++;
         check($sformatf("max_inflight_dut%0d", d), 32'(inflight[d] <= maxo[d]), 1);
         lat = (lat_mode == 0) ? 4 : int'($urandom_range(1, 5));
         while (pend[d][3'(lat)] && lat < 7) lat++;
         pend[d][3'(lat)] = 1'b1;
         last_key[d] = key;
      end
      last_hs[d]    = hs;
      prev_stall[d] = iv && !ready;
      prev_d[d]     = s;
   endtask

   initial begin : cycle_proc
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = ($urandom_range(0, 9) < 7);
         endcase
         for (int d = 0; d < 2; d++) pend[d] = pend[d] >> 1;
         bus_a.retire_valid = pend[0][0] | extra_retire;
         bus_b.retire_valid = pend[1][0] | extra_retire;
         for (int d = 0; d < 2; d++) observe(d);
      end
   end

   task automatic run_pass(input bit mid_start);
      int dn [2];
      int tail;
      dn[0] = 0;
      dn[1] = 0;
      tail  = -1;
      @(posedge clk); #1;
      start = 1'b1;
      push_pass();
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy_a", 32'(busy_a), 1);
      check("start_valid_a", 32'(bus_a.issue_valid), 1);
      check("start_layer_a", bus_a.w_layer_index, NL - 1);
      check("start_row_a", bus_a.w_row_index, 0);
      check("start_error_clear_a", 32'(error_a), 0);
      check("start_busy_b", 32'(busy_b), 1);
      check("start_error_clear_b", 32'(error_b), 0);
      for (int k = 0; k < 600 && tail != 0; k++) begin
         @(posedge clk); #1;
         start = mid_start && (k == 0);
         if (done_a) begin dn[0]++; check("done_busy_low_a", 32'(busy_a), 0); end
         if (done_b) begin dn[1]++; check("done_busy_low_b", 32'(busy_b), 0); end
         if (tail > 0) tail--;
         else if (dn[0] > 0 && dn[1] > 0) tail = 4;
      end
      start = 1'b0;
      check("done_pulses_a", 32'(dn[0]), 1);
      check("done_pulses_b", 32'(dn[1]), 1);
      check("end_error_a", 32'(error_a), 0);
      check("end_error_b", 32'(error_b), 0);
      check("rows_left_a", 32'(exp_q[0].size()), 0);
      check("rows_left_b", 32'(exp_q[1].size()), 0);
      check("end_busy_a", 32'(busy_a), 0);
   endtask

   initial begin : main
      bit found;
      maxo[0] = 8;
      maxo[1] = 2;
      clear_model();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus_a.issue_valid), 0);
      check("rst_layer", bus_a.w_layer_index, 0);
      check("rst_row", bus_a.w_row_index, 0);
      check("rst_flags", 32'({bus_a.is_update, bus_a.is_cost_layer, bus_a.backprop_cost}), 0);
      check("rst_status", 32'({busy_a, done_a, error_a}), 0);
      reset = 1'b0;

      run_pass(0);

      ready_mode = 1;
      run_pass(0);
      ready_mode = 0;

      @(posedge clk); #1;
      extra_retire = 1'b1;
      @(posedge clk); #1;
      extra_retire = 1'b0;
      @(posedge clk); #1;
      check("idle_retire_error_a", 32'(error_a), 1);
      check("idle_retire_error_b", 32'(error_b), 1);
      check("idle_retire_busy_a", 32'(busy_a), 0);
      run_pass(0);

      run_pass(1);

      @(posedge clk); #1;
      start = 1'b1;
      push_pass();
      @(posedge clk); #1;
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk); #1;
         found = bus_a.issue_valid && bus_a.is_update && (bus_a.w_layer_index == 1);
      end
      check("reached_upd_layer1", 32'(found), 1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus_a.issue_valid), 0);
      check("async_rst_index", bus_a.w_layer_index | bus_a.w_row_index, 0);
      check("async_rst_update", 32'(bus_a.is_update), 0);
      check("async_rst_busy", 32'(busy_a), 0);
      check("async_rst_valid_b", 32'(bus_b.issue_valid), 0);
      clear_model();
      @(posedge clk); #1;
      reset = 1'b0;
      run_pass(0);

      lat_mode   = 1;
      ready_mode = 2;
      repeat (3) run_pass(0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
